// File: rtl/sram_model_param_if.sv
// -----------------------------------------------------------------------------
// sram_model_param_if
// Control, address and status bundle of the asynchronous-style SRAM model.
// The bidirectional Data bus is a separate module port because it is a
// resolved tristate net.
//   master : drives ADDR, CE, OE, WE, BE_N (all strobes active low);
//            samples rd_valid, rd_count, wr_count, err_flags.
//   slave  : the memory model, which is the mirror image of master.
// -----------------------------------------------------------------------------
interface sram_model_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0]   ADDR;
    logic                CE;
    logic                OE;
    logic                WE;
    logic [DATA_W/8-1:0] BE_N;
    logic                rd_valid;
    logic [31:0]         rd_count;
    logic [31:0]         wr_count;
    logic [1:0]          err_flags;

    modport master (
        output ADDR, CE, OE, WE, BE_N,
        input  rd_valid, rd_count, wr_count, err_flags
    );

    modport slave (
        input  ADDR, CE, OE, WE, BE_N,
        output rd_valid, rd_count, wr_count, err_flags
    );
endinterface

// File: rtl/sram_model_param.sv
// -----------------------------------------------------------------------------
// sram_model_param
// Behavioural, simulation-only SRAM with byte lanes, a configurable read
// pipeline, access counters and sticky error flags.  When SYNTHESIS is
// defined the body is compiled out, which leaves an empty module with Data
// undriven.
//
// Ports
//   clock_100 : single clock, all state on its rising edge
//   reset_n   : asynchronous active-low reset (memory contents are kept)
//   Data      : bidirectional data bus, driven per lane during reads
//   bus       : sram_model_param_if.slave
//               (ADDR, CE, OE, WE, BE_N in; rd_valid, rd_count, wr_count,
//                err_flags out)
//
// Optional feature macro: SRAM_MODEL_ADDR_PATTERN_EN
//   When defined, in-range reads return ADDR resized to DATA_W instead of
//   the stored word.  Writes still update memory.
// -----------------------------------------------------------------------------
module sram_model_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 2**ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clock_100,
    input  logic              reset_n,
    inout  wire  [DATA_W-1:0] Data,
    sram_model_param_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

`ifndef SYNTHESIS
    // Memory starts out all zeros and is never touched by reset.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    logic [RD_LAT-1:0]             vld_q;
    logic [RD_LAT-1:0][DATA_W-1:0] pdat_q;
    logic [31:0]                   rd_cnt_q, rd_cnt_d;
    logic [31:0]                   wr_cnt_q, wr_cnt_d;
    logic [1:0]                    err_q, err_d;

    logic              access, rd_issue, wr_acc, clash, in_range, drive_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        access   = !bus.CE;
        rd_issue = access && !bus.OE && bus.WE;
        // WE low always wins, including OE/WE contention.
        wr_acc   = access && !bus.WE;
        clash    = access && !bus.OE && !bus.WE;
        in_range = {1'b0, bus.ADDR} < DEPTH_L;
        idx      = bus.ADDR[IDX_W-1:0];

        // Out-of-range reads return zeros in either read mode.
        rd_word = '0;
        if (in_range) begin
`ifdef SRAM_MODEL_ADDR_PATTERN_EN
            rd_word = DATA_W'(bus.ADDR);
`else
            rd_word = mem_q[idx];
`endif
        end

        rd_cnt_d = rd_issue ? rd_cnt_q + 32'd1 : rd_cnt_q;
        wr_cnt_d = wr_acc   ? wr_cnt_q + 32'd1 : wr_cnt_q;
        err_d    = err_q;
        if (clash)                err_d[0] = 1'b1;
        if (access && !in_range)  err_d[1] = 1'b1;

        drive_en = reset_n && rd_issue;
    end

    // Memory array: no reset.  The pipeline samples mem_q before this
    // non-blocking update lands, which gives read-before-write ordering.
    always_ff @(posedge clock_100) begin
        if (reset_n && wr_acc && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (!bus.BE_N[i]) mem_q[idx][8*i +: 8] <= Data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock_100 or negedge reset_n) begin
        if (!reset_n) begin
            vld_q    <= '0;
            pdat_q   <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            for (int s = RD_LAT - 1; s > 0; s--) begin
                vld_q[s]  <= vld_q[s-1];
                pdat_q[s] <= pdat_q[s-1];
            end
            vld_q[0]  <= rd_issue;
            pdat_q[0] <= rd_issue ? rd_word : '0;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.rd_valid  = vld_q[RD_LAT-1];
    assign bus.rd_count  = rd_cnt_q;
    assign bus.wr_count  = wr_cnt_q;
    assign bus.err_flags = err_q;

    // The bus follows the live strobes, so a lane is released the moment
    // its BE_N, OE, CE or WE changes, independently of the pipeline state.
    for (genvar g = 0; g < NB; g++) begin : g_lane
        assign Data[8*g +: 8] = (drive_en && !bus.BE_N[g]) ? pdat_q[RD_LAT-1][8*g +: 8] : 8'bz;
    end
`endif

endmodule

// File: tb/tb_sram_model_param.sv
// -----------------------------------------------------------------------------
// tb_sram_model_param
// Two instances share one stimulus stream: u0 with default parameters
// (RD_LAT=1, full depth) and u1 with RD_LAT=3 and DEPTH=1024.  The stimulus
// side predicts each read result from a sparse word-array model and queues
// it with the cycle at which it is due.  A monitor one time unit after each
// rising edge pops and compares rd_valid timing, lane data, counters and
// error flags.
// -----------------------------------------------------------------------------
module tb_sram_model_param;
    localparam int DW     = 16;
    localparam int AW     = 20;
    localparam int NB     = DW / 8;
    localparam int LAT0   = 1;
    localparam int LAT1   = 3;
    localparam int DEPTH1 = 1024;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    sram_model_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    sram_model_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    logic          tb_drv;
    logic [DW-1:0] tb_wd;
    wire  [DW-1:0] data0;
    wire  [DW-1:0] data1;
    assign data0 = tb_drv ? tb_wd : 'z;
    assign data1 = tb_drv ? tb_wd : 'z;

    sram_model_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT0)) u0 (
        .clock_100(clk), .reset_n(rst_n), .Data(data0), .bus(bus0));
    sram_model_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH1), .RD_LAT(LAT1)) u1 (
        .clock_100(clk), .reset_n(rst_n), .Data(data1), .bus(bus1));

    // ---------------- reference model ----------------
    logic [DW-1:0] mem_m [int];
    exp_t          q0[$];
    exp_t          q1[$];
    logic [31:0]   rd_m, wr_m;
    logic [1:0]    err_m0, err_m1;
    int            vec, bad;

    // Result of a read of address a on instance d, as required by the
    // rules: out of range -> 0, pattern mode -> address, else stored word.
    function automatic logic [DW-1:0] exp_rd(input int d, input logic [AW-1:0] a);
        if (d == 1 && int'(a) >= DEPTH1) return '0;
`ifdef SRAM_MODEL_ADDR_PATTERN_EN
        return a[DW-1:0];
`else
        return mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0;
`endif
    endfunction

    // u0 holds every 20-bit address; u1 differs only above DEPTH1, where
    // exp_rd already returns 0 for it.
    task automatic mem_write(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] wd);
        logic [DW-1:0] w;
        w = mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0;
        for (int i = 0; i < NB; i++) if (!be[i]) w[8*i +: 8] = wd[8*i +: 8];
        mem_m[int'(a)] = w;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // A released lane reads as z in a 4-state simulator and as 0 in a
    // 2-state one; either is accepted.
    task automatic chk_z(input string nm, input logic [7:0] v);
        vec++;
        if (!(v === 8'hzz || v === 8'h00)) begin
            bad++;
            $display("FAIL %s: got %h expected undriven (cycle %0d)", nm, v, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qdue(input int d);
        return (d == 0) ? q0[0].due : q1[0].due;
    endfunction

    task automatic qpop(input int d, output exp_t e);
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    task automatic mon(input int d, input logic rdv, input logic [DW-1:0] dat,
                       input logic [31:0] rc, input logic [31:0] wc, input logic [1:0] ef);
        exp_t  e;
        logic  have;
        logic  rd_mode;
        string t;
        t = (d == 0) ? "u0" : "u1";
        e.due  = 0;
        e.data = '0;
        have   = 1'b0;
        chk({t, "_rd_count"}, 64'(rc), 64'(rd_m));
        chk({t, "_wr_count"}, 64'(wc), 64'(wr_m));
        chk({t, "_err_flags"}, 64'(ef), 64'((d == 0) ? err_m0 : err_m1));
        if (!rst_n) begin
            chk({t, "_rd_valid_in_reset"}, 64'(rdv), 64'(0));
        end else if (rdv) begin
            if (qsize(d) == 0) begin
                chk({t, "_rd_valid_unexpected"}, 64'(rdv), 64'(0));
            end else begin
                qpop(d, e);
                have = 1'b1;
                chk({t, "_rd_latency"}, 64'(cyc), 64'(e.due));
            end
        end else if (qsize(d) > 0 && qdue(d) <= cyc) begin
            qpop(d, e);
            chk({t, "_rd_valid_missing"}, 64'(rdv), 64'(1));
        end

        rd_mode = rst_n && !bus0.CE && !bus0.OE && bus0.WE;
        if (tb_drv) begin
            chk({t, "_bus_during_write"}, 64'(dat), 64'(tb_wd));
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (rd_mode && !bus0.BE_N[i]) begin
                    if (have) chk({t, "_rd_lane"}, 64'(dat[8*i +: 8]), 64'(e.data[8*i +: 8]));
                end else begin
                    chk_z({t, "_lane_released"}, dat[8*i +: 8]);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon(0, bus0.rd_valid, data0, bus0.rd_count, bus0.wr_count, bus0.err_flags);
            mon(1, bus1.rd_valid, data1, bus1.rd_count, bus1.wr_count, bus1.err_flags);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_bus(input logic ce, input logic oe, input logic we,
                           input logic [AW-1:0] a, input logic [NB-1:0] be);
        bus0.CE = ce; bus0.OE = oe; bus0.WE = we; bus0.ADDR = a; bus0.BE_N = be;
        bus1.CE = ce; bus1.OE = oe; bus1.WE = we; bus1.ADDR = a; bus1.BE_N = be;
    endtask

    // Drives one access for the next rising edge and books its effect.
    task automatic apply(input logic ce, input logic oe, input logic we,
                         input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] wd);
        exp_t e0, e1;
        @(negedge clk);
        set_bus(ce, oe, we, a, be);
        tb_drv = !ce && !we;
        tb_wd  = wd;
        if (!ce) begin
            if (!oe && we) begin
                rd_m++;
                e0.due = cyc + LAT0; e0.data = exp_rd(0, a);
                e1.due = cyc + LAT1; e1.data = exp_rd(1, a);
                q0.push_back(e0);
                q1.push_back(e1);
            end
            if (!we) begin
                wr_m++;
                mem_write(a, be, wd);
            end
            if (!oe && !we) begin
                err_m0[0] = 1'b1;
                err_m1[0] = 1'b1;
            end
            if (int'(a) >= DEPTH1) err_m1[1] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b1, 1'b1, 1'b1, '0, '1, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [NB-1:0] be);
        apply(1'b0, 1'b0, 1'b1, a, be, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] wd);
        apply(1'b0, 1'b1, 1'b0, a, be, wd);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        set_bus(1'b1, 1'b1, 1'b1, '0, '1);
        tb_drv = 1'b0;
        q0.delete();
        q1.delete();
        rd_m = '0; wr_m = '0; err_m0 = '0; err_m1 = '0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [AW-1:0] pool [10] = '{20'h00010, 20'h5, 20'h1, 20'h2, 20'h3,
                                 20'h003FF, 20'h00400, 20'h0ABCD, 20'h7, 20'h8};

    initial begin
        int            op;
        logic [AW-1:0] a;
        logic [NB-1:0] be;
        logic [DW-1:0] wd;

        tb_drv = 1'b0;
        tb_wd  = '0;
        rd_m = '0; wr_m = '0; err_m0 = '0; err_m1 = '0;
        set_bus(1'b1, 1'b1, 1'b1, '0, '1);
        do_reset(3);
        idle(1);

        // Full-word write then read back.
        wr(20'h00010, 2'b00, 16'hBEEF);
        rd(20'h00010, 2'b00);
        idle(3);

        // Byte-lane merge and per-lane bus release.
        wr(20'h5, 2'b00, 16'h1234);
        wr(20'h5, 2'b01, 16'hAB00);
        rd(20'h5, 2'b00);
        rd(20'h5, 2'b10);
        wr(20'h5, 2'b11, 16'hFFFF);
        rd(20'h5, 2'b00);
        idle(3);

        // Back-to-back reads through the deep pipeline.
        wr(20'h1, 2'b00, 16'd11);
        wr(20'h2, 2'b00, 16'd22);
        wr(20'h3, 2'b00, 16'd33);
        rd(20'h1, 2'b00);
        rd(20'h2, 2'b00);
        rd(20'h3, 2'b00);
        idle(4);

        // Out-of-range write on the short instance must not alias to 0.
        wr(20'h00400, 2'b00, 16'h5555);
        rd(20'h00400, 2'b00);
        rd(20'h00000, 2'b00);
        idle(3);

        // OE/WE contention: write wins, bus stays with the bench.
        apply(1'b0, 1'b0, 1'b0, 20'h7, 2'b00, 16'h7777);
        rd(20'h7, 2'b00);
        idle(3);

        // Reset while a read is in flight; memory survives.
        rd(20'h00010, 2'b00);
        do_reset(1);
        rd(20'h00010, 2'b00);
        idle(3);

        rd(20'h0ABCD, 2'b00);
        idle(3);

        for (int i = 0; i < 320; i++) begin
            if (i == 160) do_reset(2);
            op = $urandom_range(0, 19);
            if ($urandom_range(0, 7) == 0) a = AW'($urandom);
            else                           a = pool[$urandom_range(0, 9)];
            be = NB'($urandom);
            wd = DW'($urandom);
            if (op < 4)       idle(1);
            else if (op < 11) rd(a, be);
            else if (op < 17) wr(a, be, wd);
            else if (op < 19) apply(1'b0, 1'b1, 1'b1, a, be, wd);
            else              apply(1'b0, 1'b0, 1'b0, a, be, wd);
        end
        idle(6);

        @(negedge clk);
        chk("u0_reads_outstanding", 64'(qsize(0)), 64'(0));
        chk("u1_reads_outstanding", 64'(qsize(1)), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/sram_model_param.md
SRAM_MODEL_PARAM -- requirements
Module: sram_model_param

Interface
REQ-001 Parameter DATA_W, default 16: data bus width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter ADDR_W, default 20: address width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_W: number of words implemented; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 1: read latency in clock_100 edges; range 1..4.
REQ-005 Port clock_100  input  1  single clock; all sequential state on its rising edge.
REQ-006 Port reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port Data  inout  DATA_W  bidirectional data bus.
REQ-008 Port ADDR  input  ADDR_W  word address.
REQ-009 Port CE, OE, WE  input  1 each  active-low chip enable, output enable, write enable.
REQ-010 Port BE_N  input  DATA_W/8  active-low byte-lane enables; bit i covers Data[8i+7:8i].
REQ-011 Port rd_valid  output  1  high when the read pipeline output holds data for a read issued RD_LAT edges earlier.
REQ-012 Port rd_count, wr_count  output  32 each  accepted read and write counts; wrap modulo 2**32.
REQ-013 Port err_flags  output  2  sticky errors: bit 0 OE/WE contention, bit 1 address out of range.

Function
REQ-014 Write: at a rising edge with CE=0, WE=0 and ADDR<DEPTH, each lane with BE_N[i]=0 SHALL be written from Data; other lanes SHALL retain their value.
REQ-015 A write with all BE_N high SHALL leave memory unchanged but SHALL still increment wr_count.
REQ-016 Read issue: at a rising edge with CE=0, OE=0, WE=1, the word at ADDR SHALL enter the read pipeline and rd_count SHALL increment.
REQ-017 Read data SHALL be the pre-write word when a write hits the same address in the same edge (read-before-write).
REQ-018 The read pipeline SHALL be RD_LAT registers deep; each stage SHALL carry data plus a valid bit; rd_valid SHALL equal the final stage valid bit.
REQ-019 Bus drive SHALL be combinational: when CE=0, OE=0 and WE=1, lane i SHALL drive final-stage data if BE_N[i]=0; otherwise that lane SHALL be high-impedance.
REQ-020 When CE=0, OE=0 and WE=0 in the same cycle, the write SHALL take precedence; Data SHALL not be driven; err_flags[0] SHALL set at that edge.
REQ-021 ADDR>=DEPTH with CE=0: writes SHALL be discarded, reads SHALL return all zeros, err_flags[1] SHALL set, and counters SHALL still increment.
REQ-022 Idle edges (CE=1) SHALL shift a 0 valid bit into the pipeline and SHALL leave memory and counters unchanged.
REQ-023 err_flags bits SHALL remain set until reset.
REQ-024 Memory contents SHALL initialise to all zeros at time zero.
REQ-025 The model SHALL be simulation-only; synthesis SHALL yield an empty module with Data undriven.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear all pipeline stages, rd_valid, rd_count, wr_count and err_flags to 0 and SHALL release the Data bus.
REQ-027 Reset SHALL NOT alter memory contents; a read in flight during reset SHALL be discarded.
REQ-028 The first rising edge after reset_n rises SHALL be a normal access edge.

Configuration
REQ-029 Macro SRAM_MODEL_ADDR_PATTERN_EN: when defined, read data SHALL be ADDR zero-extended or truncated to DATA_W, ignoring memory, and writes still SHALL update memory; when undefined, read data SHALL come from memory per REQ-016.

Verification
REQ-030 Default params: write 16'hBEEF to 20'h00010 with BE_N=2'b00, then read -> Data=16'hBEEF one edge later, rd_valid=1, wr_count=1, rd_count=1.
REQ-031 Write 16'h1234 to address 5, then write 16'hAB00 with BE_N=2'b01, then read -> 16'hAB34; read with BE_N=2'b10 -> Data[15:8]=Z, Data[7:0]=8'h34.
REQ-032 RD_LAT=3: issue back-to-back reads of addresses 1,2,3 holding 11,22,33 -> values appear at edges 3,4,5 with rd_valid high exactly those cycles.
REQ-033 DEPTH=1024, ADDR_W=20: write to 20'h00400 -> memory unchanged, err_flags=2'b10; assert OE=0 and WE=0 together -> err_flags=2'b11, Data undriven.
REQ-034 Issue a read, pulse reset_n low mid-latency -> rd_valid=0, counters=0, err_flags=0; prior memory data still readable after reset.
REQ-035 With SRAM_MODEL_ADDR_PATTERN_EN defined: read address 20'h0ABCD -> Data=16'hABCD regardless of stored contents.
